debug_dump_unit: RTL and testbench
==================================

# debug_dump_unit

Host-side reader for the processor's debug port. On a start pulse it snapshots PC, sweeps Debug_source_select over x0..x31, samples Debug_out for each register, and streams the result as a framed 8N1 UART byte stream on tx. It sits beside the single-cycle core at the top level: its Debug_source_select drives the core's debug select input, the core's Debug_out and PC feed back into it, and tx goes to the board UART pin.

## Interface
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); legal range 4..65535.
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clk.
- start  in  1  request a dump; sampled only in IDLE.
- PC  in  32  core program counter.
- Debug_out  in  32  core register-file read data for the current Debug_source_select (combinational in the core).
- Debug_source_select  out  5  register index presented to the core.
- tx  out  1  UART serial output, idle high.
- busy  out  1  high while a frame is in progress.
- done  out  1  one-cycle pulse when a frame completes.

## Operation
- Frame: 133 bytes. Header 0xA5, then PC as 4 bytes, then x0..x31 as 4 bytes each. All words are sent big-endian (bits 31:24 first).
- Byte format: 8N1, LSB first. One start bit (0), 8 data bits, one stop bit (1). Each bit is held exactly CLKS_PER_BIT cycles.
- FSM states:
  - IDLE -> HDR on start.
  - HDR -> PCW after the header stop bit.
  - PCW -> REG after the 4th PC byte.
  - REG stays in REG for 32 words.
  - REG -> FIN after the last stop bit of x31.
  - FIN -> IDLE unconditionally after one cycle.
- PC capture: PC is latched into the shift word on the cycle start is accepted.
- Register capture:
  - Debug_source_select for register k+1 is driven when the start bit of the last byte of word k begins.
  - Debug_out is latched into a 32-bit prefetch register 2 cycles later.
  - For x0, select is set to 0 at start acceptance and latched 2 cycles later.
  - After x31, Debug_source_select is held at 31 until IDLE, then returns to 0.
- No core coherency: the core is not halted. Each register value is whatever Debug_out shows at its own sample cycle.
- start is ignored while busy. There is no queuing; a start asserted during the FIN cycle is also ignored.
- A bit counter (0..9), a byte-within-word counter (0..3), a register counter (0..31) and a baud counter (0..CLKS_PER_BIT-1) run without wrap glitches. The register counter saturating at 31 ends the frame.

## Timing
- Reset values: tx=1, busy=0, done=0, Debug_source_select=0. FSM=IDLE and all counters 0.
- Start bit latency: start=1 seen in IDLE at edge N puts tx=0 and busy=1 from edge N (visible in cycle N+1).
- Back-to-back bytes: the start bit of byte n+1 begins on the cycle immediately after the final stop-bit cycle of byte n. There is no idle gap anywhere in the frame.
- Frame length: exactly 133*10*CLKS_PER_BIT cycles from the first start-bit cycle to the end of the last stop bit.
- Completion:
  - done=1 for exactly one cycle, the first cycle after the final stop bit.
  - busy=0 in that same cycle.
  - tx stays 1 from then on.
- Reset mid-frame: on the first edge with reset=1, tx=1, busy=0, done=0 and select=0. The partial frame is abandoned and no done pulse is issued.
- start held high continuously: a new frame begins on the first IDLE cycle after FIN, i.e. 2 cycles after the done pulse edge.

## Test plan
- Reset and idle, CLKS_PER_BIT=4: apply reset for 3 cycles and drive start=0 for 100 cycles -> tx=1, busy=0, done=0 and select=0 throughout.
- Full dump, CLKS_PER_BIT=4, PC=0x0000_0040, model core returns x_k = 0x1000_0000+k (x0 returns 0):
  - UART monitor decodes 133 bytes: A5, 00 00 00 40, 00 00 00 00, 10 00 00 01, ..., 10 00 00 1F.
  - done pulses at cycle 5320 after the first start bit.
- Bit timing, CLKS_PER_BIT=7: every tx level run is a multiple of 7 cycles. The header byte 0xA5 appears LSB first as 0,1,0,1,0,0,1,0,1,1.
- start while busy: pulse start at bytes 10 and 100 -> the frame is unaltered, only one done pulse occurs and the byte count is 133.
- Reset mid-frame: assert reset during byte 57, then pulse start -> tx returns high next edge, with no done. The new frame begins with A5 and is complete and correct.
- Live register change: model changes x5 from 0x11111111 to 0x22222222 after x5's sample cycle -> byte stream carries 0x11111111 for x5, and select timing matches the prefetch rule.

Source files
------------

// File: rtl/debug_dump_unit_if.sv
// debug_dump_unit_if: debug-port and UART signals between the dump unit and its surroundings.
interface debug_dump_unit_if;
    logic        start;
    logic [31:0] PC;
    logic [31:0] Debug_out;
    logic [4:0]  Debug_source_select;
    logic        tx;
    logic        busy;
    logic        done;
    modport master (input start, PC, Debug_out, output Debug_source_select, tx, busy, done);
    modport slave (output start, PC, Debug_out, input Debug_source_select, tx, busy, done);
endinterface

// File: rtl/debug_dump_unit.sv
// debug_dump_unit: snapshots PC and x0..x31 over the debug port and streams a 133-byte 8N1 frame on tx.
module debug_dump_unit #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input logic clk,
    input logic reset,
    debug_dump_unit_if.master dbg
);
    typedef enum logic [2:0] {IDLE, HDR, PCW, REG, FIN} state_t;
    state_t state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [3:0] bit_q, bit_d;
    logic [1:0] byte_q, byte_d, cap_q, cap_d;
    logic [4:0] reg_q, reg_d, sel_q, sel_d;
    logic [31:0] word_q, word_d, pre_q, pre_d;
    logic [7:0] cur;
    logic active, baud_end, byte_end;
    always_comb begin
        active = state_q inside {HDR, PCW, REG};
        cur = state_q == HDR ? 8'hA5 : word_q[31:24];
        baud_end = baud_q == 16'(CLKS_PER_BIT - 1);
        byte_end = baud_end && bit_q == 4'd9;
        state_d = state_q;
        baud_d = 16'd0;
        bit_d = bit_q;
        byte_d = byte_q;
        reg_d = reg_q;
        sel_d = sel_q;
        word_d = word_q;
        pre_d = cap_q == 2'd1 ? dbg.Debug_out : pre_q;
        cap_d = cap_q == 2'd0 ? 2'd0 : cap_q - 2'd1;
        case (state_q)
            IDLE: if (dbg.start) begin
                state_d = HDR;
                bit_d = 4'd0;
                byte_d = 2'd0;
                reg_d = 5'd0;
                sel_d = 5'd0;
                word_d = dbg.PC;
                cap_d = 2'd2;
            end
            FIN: begin
                state_d = IDLE;
                sel_d = 5'd0;
            end
            default: begin
                baud_d = baud_end ? 16'd0 : baud_q + 16'd1;
                if (baud_end) bit_d = bit_q + 4'd1;
                if (byte_end) begin
                    bit_d = 4'd0;
                    byte_d = byte_q + 2'd1;
                    word_d = {word_q[23:0], 8'h00};
                    if (state_q == HDR) begin
                        state_d = PCW;
                        byte_d = 2'd0;
                        word_d = word_q;
                    end else if (byte_q == 2'd3) begin
                        word_d = pre_q;
                        if (state_q == PCW) state_d = REG;
                        else if (reg_q == 5'd31) state_d = FIN;
                        else reg_d = reg_q + 5'd1;
                    end else if (state_q == REG && byte_q == 2'd2 && reg_q != 5'd31) begin
                        // next register is selected as the last byte of this word starts; sampled 2 cycles on
                        sel_d = reg_q + 5'd1;
                        cap_d = 2'd2;
                    end
                end
            end
        endcase
        dbg.tx = !active || bit_q == 4'd9 || (bit_q != 4'd0 && cur[3'(bit_q - 4'd1)]);
        dbg.busy = active;
        dbg.done = state_q == FIN;
        dbg.Debug_source_select = sel_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q <= '0;
            bit_q <= '0;
            byte_q <= '0;
            cap_q <= '0;
            reg_q <= '0;
            sel_q <= '0;
            word_q <= '0;
            pre_q <= '0;
        end else begin
            state_q <= state_d;
            baud_q <= baud_d;
            bit_q <= bit_d;
            byte_q <= byte_d;
            cap_q <= cap_d;
            reg_q <= reg_d;
            sel_q <= sel_d;
            word_q <= word_d;
            pre_q <= pre_d;
        end
    end
endmodule

// File: tb/tb_debug_dump_unit.sv
// tb_debug_dump_unit: cycle-exact frame checks against a byte-list reference model of the dump protocol.
module tb_debug_dump_unit;
    localparam int CPB = 4;
    localparam int CPB7 = 7;
    localparam int FRAME = 1330 * CPB;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    debug_dump_unit_if bus();
    debug_dump_unit_if bus7();
    logic [31:0] regs [32];
    logic [7:0] exp_bytes [133];
    int vectors = 0;
    int errors = 0;
    debug_dump_unit #(.CLKS_PER_BIT(CPB)) u_dut (.clk(clk), .reset(reset), .dbg(bus.master));
    debug_dump_unit #(.CLKS_PER_BIT(CPB7)) u_dut7 (.clk(clk), .reset(reset), .dbg(bus7.master));
    assign bus.Debug_out = bus.Debug_source_select == 5'd0 ? 32'd0 : regs[bus.Debug_source_select];
    assign bus7.Debug_out = bus7.Debug_source_select == 5'd0 ? 32'd0 : regs[bus7.Debug_source_select];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] obs();
        return {bus.tx, bus.busy, bus.done, bus.Debug_source_select};
    endfunction

    // expected {tx,busy,done,select} for cycle c of a frame, from the byte list and word layout
    function automatic logic [7:0] exp_frame(input int c);
        int b, i, s;
        logic t;
        b = c / (10 * CPB);
        i = (c % (10 * CPB)) / CPB;
        t = i == 0 ? 1'b0 : i == 9 ? 1'b1 : exp_bytes[b][i - 1];
        s = b < 8 ? 0 : ((b - 8) / 4 + 1 > 31 ? 31 : (b - 8) / 4 + 1);
        return {t, 1'b1, 1'b0, 5'(s)};
    endfunction

    task automatic frame(input logic [31:0] pc, input bit spam, input bit live, input int abort_b, input bit rnd);
        logic [31:0] w;
        logic [7:0] e;
        for (int k = 0; k < 32; k++) regs[k] = rnd ? $urandom : 32'h1000_0000 + k;
        if (live) regs[5] = 32'h1111_1111;
        exp_bytes[0] = 8'hA5;
        for (int j = 0; j < 4; j++) exp_bytes[1 + j] = pc[31 - 8 * j -: 8];
        for (int k = 0; k < 32; k++) begin
            w = k == 0 ? 32'd0 : regs[k];
            for (int j = 0; j < 4; j++) exp_bytes[5 + 4 * k + j] = w[31 - 8 * j -: 8];
        end
        bus.PC = pc;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 0; c <= FRAME + 1; c++) begin
            if (abort_b >= 0 && c == abort_b * 10 * CPB + 5) begin
                reset = 1'b1;
                tick();
                check("abort_reset", obs(), 8'h80);
                reset = 1'b0;
                for (int n = 0; n < 20; n++) begin
                    tick();
                    check("abort_idle", obs(), 8'h80);
                end
                return;
            end
            e = c < FRAME ? exp_frame(c) : c == FRAME ? 8'hBF : 8'h80;
            check($sformatf("frame c=%0d", c), obs(), e);
            if (c == 1) bus.PC = ~pc;
            bus.start = spam && (c == 100 * CPB + 3 || c == 1000 * CPB + 3 || c == FRAME);
            if (live && c == 240 * CPB + 2) regs[5] = 32'h2222_2222;
            if (c != FRAME + 1) tick();
        end
        bus.start = 1'b0;
    endtask

    task automatic bits7();
        logic [9:0] hb;
        logic prev;
        hb = {1'b1, 8'hA5, 1'b0};
        prev = 1'b1;
        bus7.PC = $urandom;
        bus7.start = 1'b1;
        tick();
        bus7.start = 1'b0;
        for (int c = 0; c <= 1330 * CPB7; c++) begin
            if (c < 10 * CPB7) check("hdr7", 64'(bus7.tx), 64'(hb[c / CPB7]));
            if (bus7.tx !== prev) check("run7", 64'(c % CPB7), 64'd0);
            prev = bus7.tx;
            if (c == 1330 * CPB7) check("done7", 64'(bus7.done), 64'd1);
            else tick();
        end
        tick();
        check("idle7", 64'({bus7.tx, bus7.busy, bus7.done}), 64'h4);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.PC = '0;
        bus7.start = 1'b0;
        bus7.PC = '0;
        for (int k = 0; k < 32; k++) regs[k] = '0;
        for (int n = 0; n < 3; n++) begin
            tick();
            check("reset", obs(), 8'h80);
        end
        reset = 1'b0;
        for (int n = 0; n < 100; n++) begin
            tick();
            check("idle", obs(), 8'h80);
        end
        frame(32'h0000_0040, 1'b0, 1'b0, -1, 1'b0);
        frame($urandom, 1'b1, 1'b0, -1, 1'b1);
        frame($urandom, 1'b0, 1'b0, 57, 1'b1);
        frame($urandom, 1'b0, 1'b0, -1, 1'b1);
        frame(32'h0000_0040, 1'b0, 1'b1, -1, 1'b0);
        frame($urandom, 1'b0, 1'b0, int'($urandom_range(1, 131)), 1'b1);
        frame($urandom, 1'($urandom_range(0, 1)), 1'b0, -1, 1'b1);
        bits7();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
